// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch queue for the PIPE fetch stage.
// Each cycle it reads one LINE_BYTES line from instruction memory into a
// circular byte array. It presents the oldest WIN_BYTES bytes and their PC
// to the split/align logic.
//
// Handshake semantics:
//   imem_req/imem_rdata/imem_err form a same-cycle read port. When imem_req
//   is high, the memory answers in the same cycle. A fill is accepted at the
//   posedge when imem_req & ~imem_err. A fault (imem_req & imem_err) latches
//   the error flag and stops further fills.
//   consume acts as a valid and illegal_consume as its combinational refusal.
//   Bytes are removed at the posedge only when consume & ~illegal_consume
//   and no redirect is present. The window always shows the current queue
//   head, so there is no separate ready.
module fetch_prefetch_buffer #(
   parameter int                ADDR_W      = 64,
   parameter int                LINE_BYTES  = 8,
   parameter int                DEPTH_BYTES = 32,
   parameter int                WIN_BYTES   = 10,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               redirect,
   input  logic [ADDR_W-1:0]                  redirect_pc,
   output logic                               imem_req,
   output logic [ADDR_W-1:0]                  imem_addr,
   input  logic [8*LINE_BYTES-1:0]            imem_rdata,
   input  logic                               imem_err,
   output logic [8*WIN_BYTES-1:0]             out_bytes,
   output logic [$clog2(DEPTH_BYTES+1)-1:0]   out_count,
   output logic [ADDR_W-1:0]                  out_pc,
   output logic                               out_fill_err,
   input  logic                               consume,
   input  logic [3:0]                         consume_len,
   output logic                               illegal_consume
);

   localparam int PTR_W = $clog2(DEPTH_BYTES);
   localparam int CNT_W = $clog2(DEPTH_BYTES + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_BYTES);
   localparam logic [CNT_W-1:0] LINE_C  = CNT_W'(LINE_BYTES);

   // Byte storage; contents are only meaningful inside [head, head+count).
   logic [7:0]        mem [DEPTH_BYTES];

   logic [PTR_W-1:0]  head_ptr, head_ptr_nxt;
   logic [CNT_W-1:0]  count, count_nxt;
   logic [ADDR_W-1:0] pc_q, pc_nxt;
   logic [ADDR_W-1:0] fill_pc, fill_pc_nxt;
   logic              err, err_nxt;

   logic [CNT_W-1:0]  free_space;
   logic [CNT_W-1:0]  len_ext;
   logic [PTR_W-1:0]  tail_ptr;
   logic              do_fill;
   logic              do_fault;
   logic              do_consume;

   // Request and consume qualification use only the current state. A consume
   // in the same cycle therefore never opens room for a fill.
   always_comb begin
      free_space      = DEPTH_C - count;
      len_ext         = CNT_W'(consume_len);
      tail_ptr        = head_ptr + PTR_W'(count);
      illegal_consume = consume & ((consume_len == 4'd0) | (len_ext > count));
      imem_req        = rst_n & ~redirect & ~err & (free_space >= LINE_C);
      imem_addr       = fill_pc;
      do_fill         = imem_req & ~imem_err;
      do_fault        = imem_req & imem_err;
      do_consume      = consume & ~illegal_consume & ~redirect;
   end

   // Next state. A redirect overrides fill and consume. Otherwise fill and
   // consume combine, and both are computed from pre-update values.
   always_comb begin
      head_ptr_nxt = head_ptr;
      count_nxt    = count;
      pc_nxt       = pc_q;
      fill_pc_nxt  = fill_pc;
      err_nxt      = err;
      if (redirect) begin
         head_ptr_nxt = '0;
         count_nxt    = '0;
         pc_nxt       = redirect_pc;
         fill_pc_nxt  = redirect_pc;
         err_nxt      = 1'b0;
      end else begin
         count_nxt = count + (do_fill ? LINE_C : '0) - (do_consume ? len_ext : '0);
         if (do_consume) begin
            head_ptr_nxt = head_ptr + PTR_W'(consume_len);
            pc_nxt       = pc_q + ADDR_W'(consume_len);
         end
         if (do_fill) begin
            fill_pc_nxt = fill_pc + ADDR_W'(LINE_BYTES);
         end
         if (do_fault) begin
            err_nxt = 1'b1;
         end
      end
   end

   // Queue bookkeeping register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_ptr <= '0;
         count    <= '0;
         pc_q     <= RESET_PC;
         fill_pc  <= RESET_PC;
         err      <= 1'b0;
      end else begin
         head_ptr <= head_ptr_nxt;
         count    <= count_nxt;
         pc_q     <= pc_nxt;
         fill_pc  <= fill_pc_nxt;
         err      <= err_nxt;
      end
   end

   // Line write at the tail. The tail comes from the pre-consume head and
   // count, so a same-cycle consume cannot shift where the line lands.
   always_ff @(posedge clk) begin
      if (do_fill) begin
         for (int i = 0; i < LINE_BYTES; i++) begin
            mem[tail_ptr + PTR_W'(i)] <= imem_rdata[8*i +: 8];
         end
      end
   end

   // Output window. It wraps around the array end, and slots past count read zero.
   always_comb begin
      out_bytes = '0;
      for (int k = 0; k < WIN_BYTES; k++) begin
         if (CNT_W'(k) < count) begin
            out_bytes[8*k +: 8] = mem[head_ptr + PTR_W'(k)];
         end
      end
   end

   // Remaining status outputs come directly from state.
   always_comb begin
      out_count    = count;
      out_pc       = pc_q;
      out_fill_err = err;
   end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer with default parameters.
// The memory model returns byte value = address[7:0] and can raise a fault
// at one chosen address.
module tb_fetch_prefetch_buffer;

   logic         clk;
   logic         rst_n;
   logic         redirect;
   logic [63:0]  redirect_pc;
   logic         imem_req;
   logic [63:0]  imem_addr;
   logic [63:0]  imem_rdata;
   logic         imem_err;
   logic [79:0]  out_bytes;
   logic [5:0]   out_count;
   logic [63:0]  out_pc;
   logic         out_fill_err;
   logic         consume;
   logic [3:0]   consume_len;
   logic         illegal_consume;

   logic         err_en;
   logic [63:0]  err_addr;

   int           n_checks;
   int           n_fails;

   fetch_prefetch_buffer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .imem_err        (imem_err),
      .out_bytes       (out_bytes),
      .out_count       (out_count),
      .out_pc          (out_pc),
      .out_fill_err    (out_fill_err),
      .consume         (consume),
      .consume_len     (consume_len),
      .illegal_consume (illegal_consume)
   );

   // Clock and reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: each byte holds the low 8 bits of its own address.
   always_comb begin
      imem_rdata = '0;
      for (int i = 0; i < 8; i++) begin
         imem_rdata[8*i +: 8] = imem_addr[7:0] + 8'(i);
      end
      imem_err = err_en && (imem_addr == err_addr);
   end

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare one observed value against a hand-computed expectation.
   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a consume request and let combinational outputs settle.
   task automatic drive_consume(input logic en, input logic [3:0] len);
      consume     = en;
      consume_len = len;
      #1;
   endtask

   initial begin
      n_checks    = 0;
      n_fails     = 0;
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      consume     = 1'b0;
      consume_len = 4'd0;
      err_en      = 1'b0;
      err_addr    = '0;

      // Test 1: reset, then four fills until the queue is full.
      step();
      check("rst_req", 80'(imem_req), 80'd0);
      check("rst_count", 80'(out_count), 80'd0);
      step();
      check("rst_bytes", out_bytes, 80'd0);
      check("rst_err", 80'(out_fill_err), 80'd0);
      rst_n = 1'b1;
      #1;
      check("fill0_req", 80'(imem_req), 80'd1);
      check("fill0_addr", 80'(imem_addr), 80'd0);
      step();
      check("fill1_addr", 80'(imem_addr), 80'd8);
      check("fill1_count", 80'(out_count), 80'd8);
      step();
      check("fill2_addr", 80'(imem_addr), 80'd16);
      step();
      check("fill3_addr", 80'(imem_addr), 80'd24);
      check("fill3_req", 80'(imem_req), 80'd1);
      step();
      check("full_count", 80'(out_count), 80'd32);
      check("full_req", 80'(imem_req), 80'd0);
      check("full_bytes", out_bytes, 80'h09080706050403020100);
      check("full_pc", 80'(out_pc), 80'd0);

      // Test 2: consumes of 10 bytes, including head wrap past 31.
      drive_consume(1'b1, 4'd10);
      check("c1_illegal", 80'(illegal_consume), 80'd0);
      check("c1_req", 80'(imem_req), 80'd0);
      step();
      drive_consume(1'b0, 4'd0);
      check("c1_count", 80'(out_count), 80'd22);
      check("c1_pc", 80'(out_pc), 80'd10);
      check("c1_byte0", 80'(out_bytes[7:0]), 80'h0a);
      check("c1_req_after", 80'(imem_req), 80'd1);
      check("c1_addr_after", 80'(imem_addr), 80'd32);
      step();
      check("c1_fill_count", 80'(out_count), 80'd30);
      check("c1_bytes", out_bytes, 80'h131211100f0e0d0c0b0a);
      drive_consume(1'b1, 4'd10);
      check("c2_req", 80'(imem_req), 80'd0);
      step();
      drive_consume(1'b0, 4'd0);
      check("c2_count", 80'(out_count), 80'd20);
      check("c2_addr", 80'(imem_addr), 80'd40);
      step();
      check("c2_fill_count", 80'(out_count), 80'd28);
      drive_consume(1'b1, 4'd10);
      check("c3_req", 80'(imem_req), 80'd0);
      step();
      check("c3_count", 80'(out_count), 80'd18);
      check("c3_pc", 80'(out_pc), 80'd30);
      check("c3_wrap_bytes", out_bytes, 80'h27262524232221201f1e);
      check("c4_req", 80'(imem_req), 80'd1);
      check("c4_addr", 80'(imem_addr), 80'd48);
      step();
      drive_consume(1'b0, 4'd0);
      check("c4_count", 80'(out_count), 80'd16);
      check("c4_pc", 80'(out_pc), 80'd40);
      check("c4_bytes", out_bytes, 80'h31302f2e2d2c2b2a2928);

      // Test 3: fill together with consume, then the no-room case.
      step();
      check("t3_count24", 80'(out_count), 80'd24);
      drive_consume(1'b1, 4'd2);
      check("t3_req", 80'(imem_req), 80'd1);
      check("t3_addr", 80'(imem_addr), 80'd64);
      step();
      check("t3_count30", 80'(out_count), 80'd30);
      check("t3_pc", 80'(out_pc), 80'd42);
      drive_consume(1'b1, 4'd4);
      step();
      check("t3_count26", 80'(out_count), 80'd26);
      drive_consume(1'b1, 4'd10);
      check("t3_noroom_req", 80'(imem_req), 80'd0);
      step();
      drive_consume(1'b0, 4'd0);
      check("t3_count16", 80'(out_count), 80'd16);
      check("t3_pc56", 80'(out_pc), 80'd56);
      check("t3_bytes", out_bytes, 80'h41403f3e3d3c3b3a3938);

      // Test 4: a redirect with a full queue overrides a simultaneous consume.
      step();
      step();
      check("t4_full", 80'(out_count), 80'd32);
      redirect    = 1'b1;
      redirect_pc = 64'h100;
      drive_consume(1'b1, 4'd10);
      check("t4_req_redir", 80'(imem_req), 80'd0);
      step();
      redirect = 1'b0;
      drive_consume(1'b0, 4'd0);
      check("t4_count", 80'(out_count), 80'd0);
      check("t4_pc", 80'(out_pc), 80'h100);
      check("t4_req", 80'(imem_req), 80'd1);
      check("t4_addr", 80'(imem_addr), 80'h100);
      check("t4_bytes", out_bytes, 80'd0);

      // Test 5: a fetch fault at address 16 halts filling.
      redirect    = 1'b1;
      redirect_pc = 64'h0;
      #1;
      check("t5_redir_req", 80'(imem_req), 80'd0);
      step();
      redirect = 1'b0;
      err_en   = 1'b1;
      err_addr = 64'd16;
      step();
      step();
      #1;
      check("t5_err_addr", 80'(imem_addr), 80'd16);
      check("t5_err_in", 80'(imem_err), 80'd1);
      step();
      check("t5_count", 80'(out_count), 80'd16);
      check("t5_fill_err", 80'(out_fill_err), 80'd1);
      check("t5_req", 80'(imem_req), 80'd0);
      step();
      check("t5_count_hold", 80'(out_count), 80'd16);
      check("t5_addr_hold", 80'(imem_addr), 80'd16);
      drive_consume(1'b1, 4'd10);
      step();
      drive_consume(1'b0, 4'd0);
      check("t5_count6", 80'(out_count), 80'd6);

      // Test 6: illegal consumes are refused and leave state unchanged.
      drive_consume(1'b1, 4'd10);
      check("t6_illegal_long", 80'(illegal_consume), 80'd1);
      step();
      check("t6_count_long", 80'(out_count), 80'd6);
      check("t6_pc_long", 80'(out_pc), 80'd10);
      drive_consume(1'b1, 4'd0);
      check("t6_illegal_zero", 80'(illegal_consume), 80'd1);
      step();
      check("t6_count_zero", 80'(out_count), 80'd6);
      drive_consume(1'b1, 4'd6);
      check("t6_legal", 80'(illegal_consume), 80'd0);
      step();
      drive_consume(1'b0, 4'd0);
      check("t5_drain_count", 80'(out_count), 80'd0);
      check("t5_drain_err", 80'(out_fill_err), 80'd1);
      check("t5_drain_pc", 80'(out_pc), 80'd16);
      err_en      = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 64'h40;
      step();
      redirect = 1'b0;
      #1;
      check("t5_err_clear", 80'(out_fill_err), 80'd0);
      check("t5_new_addr", 80'(imem_addr), 80'h40);
      check("t5_new_req", 80'(imem_req), 80'd1);
      step();
      check("t5_new_bytes", out_bytes, 80'h00004746454443424140);

      // Reset in mid-operation takes priority over redirect and consume.
      rst_n       = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 64'h200;
      drive_consume(1'b1, 4'd4);
      check("mid_rst_req", 80'(imem_req), 80'd0);
      step();
      check("mid_rst_count", 80'(out_count), 80'd0);
      check("mid_rst_pc", 80'(out_pc), 80'd0);
      rst_n    = 1'b1;
      redirect = 1'b0;
      drive_consume(1'b0, 4'd0);
      check("mid_rst_addr", 80'(imem_addr), 80'd0);
      check("mid_rst_req_after", 80'(imem_req), 80'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
Parametrised byte-queue prefetch buffer for the PIPE fetch stage of the Y86-64 processor. It reads LINE_BYTES of instruction memory per cycle into a circular byte buffer. It presents the oldest WIN_BYTES bytes, together with their PC, to the fetch/split-align logic, which consumes 1–10 bytes per instruction. PC redirects (mispredict or ret) flush the queue and restart filling at the new PC.

Parameters:
ADDR_W, 64, PC/address width
LINE_BYTES, 8, bytes returned per imem read; power of 2
DEPTH_BYTES, 32, queue capacity in bytes; power of 2, ≥ WIN_BYTES+LINE_BYTES
WIN_BYTES, 10, output window width (max Y86 instruction length)
RESET_PC, 0, PC loaded at reset

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
redirect  in  1  flush queue and restart at redirect_pc
redirect_pc  in  ADDR_W  new fetch PC
imem_req  out  1  read request this cycle
imem_addr  out  ADDR_W  byte address of read; any alignment
imem_rdata  in  8*LINE_BYTES  same-cycle read data; [7:0] = byte at imem_addr
imem_err  in  1  same-cycle read error (invalid address)
out_bytes  out  8*WIN_BYTES  window; [7:0] = byte at out_pc; slots ≥ out_count driven 0
out_count  out  clog2(DEPTH_BYTES+1)  valid bytes in queue
out_pc  out  ADDR_W  PC of oldest queued byte
out_fill_err  out  1  fill halted by imem_err; bytes before the fault remain valid
consume  in  1  remove consume_len bytes at posedge
consume_len  in  4  bytes to remove, 1..WIN_BYTES
illegal_consume  out  1  combinational: consume with consume_len > out_count or consume_len = 0

Behaviour:
- Reset is synchronous and active-low: while rst_n=0 at posedge, the block loads count=0, head_ptr=0, out_pc=RESET_PC, fill_pc=RESET_PC, err=0.
  - imem_req=0 while rst_n=0.
  - All outputs are derived from this state (out_bytes=0, out_fill_err=0).
- State:
  - circular byte array of DEPTH_BYTES;
  - head_ptr, clog2(DEPTH_BYTES) bits, wraps mod DEPTH_BYTES;
  - count;
  - out_pc;
  - fill_pc = out_pc + count, tracked explicitly;
  - err flag.
- imem_req = rst_n & ~redirect & ~err & (DEPTH_BYTES − count ≥ LINE_BYTES). Free space is evaluated on current count only; a same-cycle consume does not enable a fill.
- imem_addr = fill_pc, combinational.
- Fill (imem_req & ~imem_err):
  - write LINE_BYTES bytes at (head_ptr+count+i) mod DEPTH_BYTES;
  - fill_pc += LINE_BYTES;
  - count += LINE_BYTES.
- Fill with imem_err: no bytes written, err←1, fill_pc unchanged.
- Consume (consume & ~illegal_consume & ~redirect):
  - head_ptr += consume_len mod DEPTH;
  - out_pc += consume_len;
  - count −= consume_len.
- Illegal consume is ignored and leaves state unchanged; illegal_consume is asserted the same cycle.
- Fill and consume in the same cycle: count_next = count − consume_len + LINE_BYTES. Byte writes land at positions computed from the pre-consume head_ptr and count.
- Redirect has priority over fill and consume:
  - count←0, head_ptr←0, out_pc←redirect_pc, fill_pc←redirect_pc, err←0;
  - no imem_req that cycle; the first fill is on the next cycle.
- Latency:
  - from redirect or reset release, the first bytes are visible one cycle after the first fill cycle;
  - sustained throughput is LINE_BYTES per cycle.
- Address arithmetic is mod 2^ADDR_W, and pointer arithmetic is mod DEPTH_BYTES. Window reads wrap across the array end transparently.
- When err=1, fills stop until redirect or reset. Queued bytes remain consumable, and out_fill_err stays 1.
- Reset mid-operation discards the queue and err regardless of redirect or consume.

Test Plan:
1. rst_n=0 for 2 cycles, then 1, with memory bytes = address[7:0]:
   - during reset imem_req=0 and out_count=0;
   - fills occur at 0, 8, 16, 24;
   - out_count reaches 32 and imem_req drops to 0;
   - out_bytes = 0x09..0x00 (byte0 = 0x00), out_pc=0.
2. Full queue, consume_len=10:
   - out_count=22, out_pc=10, out_bytes[7:0]=0x0A;
   - next cycle imem_addr=32 fills, out_count=30;
   - repeated consumes wrap head_ptr past 31 with correct bytes, e.g. out_pc=40 shows 0x28.
3. count=24, consume_len=2 with a fill in the same cycle -> count=30 and out_pc advances by 2. At count=26 with consume_len=10, no fill occurs that cycle (free space 6 < 8) -> count=16.
4. redirect with redirect_pc=0x100 while consume=1 and the queue is full:
   - next cycle out_count=0, out_pc=0x100, imem_req=1, imem_addr=0x100;
   - consume is ignored.
5. imem_err asserted when imem_addr=16:
   - out_count holds at 16, out_fill_err=1, imem_req=0;
   - consuming 16 bytes leaves count 0 with err still set;
   - redirect to 0x40 clears out_fill_err.
6. out_count=6, consume_len=10 -> illegal_consume=1, state unchanged. consume_len=0 -> illegal_consume=1.
